// File: rtl/sprite_color_encoder.sv
// Streaming RGB444 -> 9-colour palette quantizer writing 4-bit indices into sprite BRAM.
// Three register stages (pixel, distances, argmin) at one pixel per cycle; one frame per start.
module sprite_color_encoder #(
   parameter int          DEPTH   = 4096,
   parameter int          ADDR_W  = 12,
   parameter logic [11:0] KEY_RGB = 12'hF0F
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [11:0]       s_rgb,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [3:0]        bram_din,
   output logic              busy,
   output logic              done
);

   // Handshake: a pixel transfers on a rising edge where s_valid and s_ready are both high.
   // s_ready is registered, so it never depends on s_valid in the same cycle.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Entry k of this table is palette index k+1.
   localparam logic [11:0] PALETTE [8] = '{
      12'hD42, 12'h921, 12'hFF9, 12'h210,
      12'h778, 12'h6B4, 12'hDD0, 12'hFFF
   };

   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W:0]   cnt;
   logic              hs;

   logic              v1;
   logic [11:0]       rgb1;
   logic              key1;
   logic              last1;
   logic [ADDR_W-1:0] addr1;

   logic              v2;
   logic [5:0]        dist2 [8];
   logic              key2;
   logic              last2;
   logic [ADDR_W-1:0] addr2;

   logic [5:0]        dist_c [8];
   logic [3:0]        best_idx;
   logic [5:0]        best_d;

   assign hs = s_valid && s_ready;

   function automatic logic [3:0] adiff(input logic [3:0] a, input logic [3:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         dist_c[i] = 6'(adiff(rgb1[11:8], PALETTE[i][11:8]))
                   + 6'(adiff(rgb1[7:4],  PALETTE[i][7:4]))
                   + 6'(adiff(rgb1[3:0],  PALETTE[i][3:0]));
      end
   end

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      best_idx = 4'd1;
      best_d   = dist2[0];
      for (int i = 1; i < 8; i++) begin
         if (dist2[i] < best_d) begin
            best_d   = dist2[i];
            best_idx = 4'(i + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         s_ready <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  cnt     <= '0;
                  s_ready <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               if (hs) begin
                  cnt <= cnt + (ADDR_W+1)'(1);
                  if (cnt == LAST) begin
                     state   <= FLUSH;
                     s_ready <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               // done is high for exactly the final write; leave once it has been shown.
               if (done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               s_ready <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         rgb1      <= '0;
         key1      <= 1'b0;
         last1     <= 1'b0;
         addr1     <= '0;
         v2        <= 1'b0;
         key2      <= 1'b0;
         last2     <= 1'b0;
         addr2     <= '0;
         for (int i = 0; i < 8; i++) dist2[i] <= '0;
         bram_we   <= 1'b0;
         bram_addr <= '0;
         bram_din  <= '0;
         done      <= 1'b0;
      end else begin
         v1 <= hs;
         if (hs) begin
            rgb1  <= s_rgb;
            key1  <= (s_rgb == KEY_RGB);
            last1 <= (cnt == LAST);
            addr1 <= cnt[ADDR_W-1:0];
         end
         v2 <= v1;
         if (v1) begin
            for (int i = 0; i < 8; i++) dist2[i] <= dist_c[i];
            key2  <= key1;
            last2 <= last1;
            addr2 <= addr1;
         end
         bram_we <= v2;
         done    <= v2 && last2;
         if (v2) begin
            bram_addr <= addr2;
            bram_din  <= key2 ? 4'd0 : best_idx;
         end
      end
   end

endmodule

// File: tb/tb_sprite_color_encoder.sv
// Bench for sprite_color_encoder: cycle-level reference model with a pending-write queue,
// checked every cycle, plus literal expectations on captured BRAM contents and done pulses.
module tb_sprite_color_encoder;

   localparam int DEPTH  = 9;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [11:0]       s_rgb = '0;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [3:0]        bram_din;
   logic              busy;
   logic              done;

   int total = 0;
   int bad   = 0;

   sprite_color_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_rgb     (s_rgb),
      .bram_we   (bram_we),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   logic [11:0] pal [1:8] = '{12'hD42, 12'h921, 12'hFF9, 12'h210,
                              12'h778, 12'h6B4, 12'hDD0, 12'hFFF};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   // Nearest palette index by Manhattan distance; exact key gives 0, ties go to the lower index.
   function automatic int nearest(input logic [11:0] rgb);
      int best, bd, d;
      logic [11:0] p;
      if (rgb == 12'hF0F) return 0;
      best = 1;
      bd   = 1000;
      for (int i = 1; i <= 8; i++) begin
         p = pal[i];
         d = absd(int'(rgb[11:8]), int'(p[11:8])) + absd(int'(rgb[7:4]), int'(p[7:4]))
           + absd(int'(rgb[3:0]), int'(p[3:0]));
         if (d < bd) begin
            bd   = d;
            best = i;
         end
      end
      return best;
   endfunction

   // ---------------- scoreboard / reference model ----------------
   typedef struct {
      int due;
      int addr;
      int idx;
      bit last;
   } wr_t;

   wr_t  exp_q[$];
   int   cyc = 0;
   bit   m_active = 1'b0;
   bit   m_ready  = 1'b0;
   int   m_cnt    = 0;

   logic [3:0] mem [16];
   int   wr_cnt   = 0;
   int   done_cnt = 0;

   always @(negedge clk) begin : compare
      bit  e_we, e_done, cur_active;
      wr_t w;
      e_we   = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      e_done = e_we && exp_q[0].last;
      chk("s_ready", 32'(s_ready), 32'(m_ready));
      chk("busy", 32'(busy), 32'(m_active));
      chk("bram_we", 32'(bram_we), 32'(e_we));
      chk("done", 32'(done), 32'(e_done));
      if (e_we) begin
         chk("bram_addr", 32'(bram_addr), 32'(exp_q[0].addr));
         chk("bram_din", 32'(bram_din), 32'(exp_q[0].idx));
      end
      if (bram_we === 1'b1) begin
         mem[bram_addr] = bram_din;
         wr_cnt++;
      end
      if (done === 1'b1) done_cnt++;

      cur_active = m_active;
      if (rst) begin
         m_active = 1'b0;
         m_ready  = 1'b0;
         m_cnt    = 0;
         exp_q.delete();
      end else begin
         if (e_we) begin
            void'(exp_q.pop_front());
            if (e_done) m_active = 1'b0;
         end
         if (s_valid && m_ready) begin
            w.due  = cyc + 3;
            w.addr = m_cnt;
            w.idx  = nearest(s_rgb);
            w.last = (m_cnt == DEPTH - 1);
            exp_q.push_back(w);
            m_cnt++;
            if (m_cnt == DEPTH) m_ready = 1'b0;
         end
         if (start && !cur_active) begin
            m_active = 1'b1;
            m_ready  = 1'b1;
            m_cnt    = 0;
         end
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic step(input bit st, input bit v, input logic [11:0] rgb);
      start   = st;
      s_valid = v;
      s_rgb   = rgb;
      @(posedge clk);
      #1;
      start   = 1'b0;
      s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL done_timeout t=%0t got=0 want=1", $time);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cap();
      for (int i = 0; i < 16; i++) mem[i] = 4'hx;
      wr_cnt = 0;
   endtask

   logic [11:0] pix_pal  [9] = '{12'hD42, 12'h921, 12'hFF9, 12'h210, 12'h778,
                                 12'h6B4, 12'hDD0, 12'hFFF, 12'hF0F};
   logic [3:0]  idx_pal  [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0};
   logic [11:0] pix_thr  [5] = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF};

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog t=%0t got=running want=finished", $time);
      $fatal(1);
   end

   initial begin : main
      int d0;

      chk("model_000", 32'(nearest(12'h000)), 32'd4);
      chk("model_FFE", 32'(nearest(12'hFFE)), 32'd8);
      chk("model_FFC", 32'(nearest(12'hFFC)), 32'd3);
      chk("model_B41", 32'(nearest(12'hB41)), 32'd1);
      chk("model_key", 32'(nearest(12'hF0F)), 32'd0);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_addr", 32'(bram_addr), 32'd0);
      chk("rst_din", 32'(bram_din), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd0);

      // Exact palette colours, start cycle carries no valid pixel.
      clear_cap();
      step(1'b1, 1'b0, 12'h000);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, pix_pal[i]);
      wait_done();
      for (int i = 0; i < 9; i++) chk($sformatf("pal_mem%0d", i), 32'(mem[i]), 32'(idx_pal[i]));
      chk("pal_done_cnt", 32'(done_cnt), 32'd1);

      // Nearest/tie vectors, then throttled stream with start during flush.
      idle(2);
      clear_cap();
      d0 = done_cnt;
      step(1'b1, 1'b0, 12'h000);
      step(1'b0, 1'b1, 12'h000);
      step(1'b0, 1'b1, 12'hFFE);
      step(1'b0, 1'b1, 12'hFFC);
      step(1'b0, 1'b1, 12'hB41);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, pix_thr[i]);
         step(1'b0, 1'b0, 12'h000);
      end
      step(1'b1, 1'b0, 12'h000);
      wait_done();
      idle(3);
      chk("near_000", 32'(mem[0]), 32'd4);
      chk("near_FFE", 32'(mem[1]), 32'd8);
      chk("near_FFC", 32'(mem[2]), 32'd3);
      chk("near_B41", 32'(mem[3]), 32'd1);
      chk("thr_wr_cnt", 32'(wr_cnt), 32'd9);
      chk("thr_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("thr_busy_after", 32'(busy), 32'd0);

      // Frame boundary: valid held high well past DEPTH pixels.
      clear_cap();
      d0 = done_cnt;
      step(1'b1, 1'b0, 12'h000);
      for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 12'h100 + 12'(i));
      idle(4);
      chk("bnd_wr_cnt", 32'(wr_cnt), 32'd9);
      chk("bnd_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("bnd_mem0", 32'(mem[0]), 32'd4);

      // Reset mid-frame drops in-flight pixels.
      clear_cap();
      d0 = done_cnt;
      step(1'b1, 1'b0, 12'h000);
      step(1'b0, 1'b1, 12'hD42);
      step(1'b0, 1'b1, 12'h921);
      rst = 1'b1;
      step(1'b0, 1'b1, 12'hFFF);
      rst = 1'b0;
      idle(6);
      chk("mid_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("mid_done_cnt", 32'(done_cnt - d0), 32'd0);
      chk("mid_we", 32'(bram_we), 32'd0);
      chk("mid_addr", 32'(bram_addr), 32'd0);
      chk("mid_din", 32'(bram_din), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_ready", 32'(s_ready), 32'd0);

      // Restart after reset, then a back-to-back frame started the cycle after done.
      clear_cap();
      d0 = done_cnt;
      step(1'b1, 1'b0, 12'h000);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, pix_pal[i]);
      wait_done();
      chk("b2b_first_mem0", 32'(mem[0]), 32'd1);
      step(1'b1, 1'b0, 12'h000);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, pix_pal[8 - i]);
      wait_done();
      idle(3);
      for (int i = 0; i < 9; i++) chk($sformatf("b2b_mem%0d", i), 32'(mem[i]), 32'(idx_pal[8 - i]));
      chk("b2b_wr_cnt", 32'(wr_cnt), 32'd18);
      chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
